reg_mem_2r1w: RTL and testbench

REG_MEM_2R1W -- requirements
Module: reg_mem_2r1w

---
 rtl/reg_mem_2r1w.sv | 181 ++++++++++++++++++
 tb/tb_reg_mem_2r1w.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_2r1w.sv
// rtl/reg_mem_2r1w.sv - two-read one-write register memory with clear sweep
//
// Register file of DEPTH = 2**ADDR_W entries, DATA_W bits each, with one
// write port and two independent registered read ports.  A CLEAR state
// zeroes the array one entry per cycle. Reset enters CLEAR. A clr_req
// seen while READY also enters CLEAR.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   clr_req    request a full clear sweep (honoured only in READY)
//   WR_en      write request
//   WR_addr    write address
//   WR_data    write data
//   RD_en1/2   read request, port 1 / port 2
//   RD_addr1/2 read address, port 1 / port 2
//   RD_out1/2  registered read data (holds when no read is issued)
//   RD_valid1/2 read data valid, one cycle after an accepted read
//   wr_success one-cycle pulse after each accepted write
//   ready      high in READY, when reads and writes are accepted

module reg_mem_2r1w #(
   parameter int          DATA_W   = 8,
   parameter int          ADDR_W   = 3,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic              WR_en,
   input  logic [ADDR_W-1:0] WR_addr,
   input  logic [DATA_W-1:0] WR_data,
   input  logic              RD_en1,
   input  logic [ADDR_W-1:0] RD_addr1,
   input  logic              RD_en2,
   input  logic [ADDR_W-1:0] RD_addr2,
   output logic [DATA_W-1:0] RD_out1,
   output logic [DATA_W-1:0] RD_out2,
   output logic              RD_valid1,
   output logic              RD_valid2,
   output logic              wr_success,
   output logic              ready
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [ADDR_W-1:0] clr_ptr_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              sweep_we;
   logic              wr_zero_blocked;
   logic              wr_accept;
   logic              rd_fire1;
   logic              rd_fire2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // clr_req is only looked at in READY, so a request arriving mid-sweep
   // never restarts the sweep.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_ptr_q == PTR_LAST) begin
               state_d   = ST_READY;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   assign ready = (state_q == ST_READY);

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   assign wr_zero_blocked = (ZERO_REG != 0) && (WR_addr == '0);

   // rst in the same cycle drops the write; clr_req wins over WR_en.
   assign wr_accept = ready && WR_en && !clr_req && !wr_zero_blocked && !rst;

   assign sweep_we  = (state_q == ST_CLEAR) && !rst;

   // The array has no reset term: its contents come only from the sweep
   // and from accepted writes. Sweep and write are mutually exclusive
   // because a write needs READY.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[clr_ptr_q] <= '0;
      end else if (wr_accept) begin
         mem[WR_addr] <= WR_data;
      end
   end

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   // A read colliding with an accepted write to the same address returns
   // the new data. The hardwired-zero register overrides both sources.
   always_comb begin
      rd_data1 = mem[RD_addr1];
      if (wr_accept && (WR_addr == RD_addr1)) begin
         rd_data1 = WR_data;
      end
      if ((ZERO_REG != 0) && (RD_addr1 == '0)) begin
         rd_data1 = '0;
      end
   end

   always_comb begin
      rd_data2 = mem[RD_addr2];
      if (wr_accept && (WR_addr == RD_addr2)) begin
         rd_data2 = WR_data;
      end
      if ((ZERO_REG != 0) && (RD_addr2 == '0)) begin
         rd_data2 = '0;
      end
   end

   assign rd_fire1 = ready && RD_en1 && !rst;
   assign rd_fire2 = ready && RD_en2 && !rst;

   // RD_outN only loads on an accepted read, so entering CLEAR leaves the
   // last read data visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_success <= 1'b0;
         RD_valid1  <= 1'b0;
         RD_valid2  <= 1'b0;
         RD_out1    <= '0;
         RD_out2    <= '0;
      end else begin
         wr_success <= wr_accept;
         RD_valid1  <= rd_fire1;
         RD_valid2  <= rd_fire2;
         if (rd_fire1) begin
            RD_out1 <= rd_data1;
         end
         if (rd_fire2) begin
            RD_out2 <= rd_data2;
         end
      end
   end

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// tb/tb_reg_mem_2r1w.sv - self-checking bench for reg_mem_2r1w

module tb_reg_mem_2r1w;

   logic       clk;
   logic       rst;
   logic       clr_req;
   logic       WR_en;
   logic [2:0] WR_addr;
   logic [7:0] WR_data;
   logic       RD_en1;
   logic [2:0] RD_addr1;
   logic       RD_en2;
   logic [2:0] RD_addr2;

   logic [7:0] RD_out1, RD_out2;
   logic       RD_valid1, RD_valid2, wr_success, ready;

   logic [7:0] rz1, rz2;
   logic       vz1, vz2, wsz, rdyz;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0] qz[$];
   logic [7:0] exp_mem[8];
   logic [7:0] e1, e2, ez;
   logic [7:0] last1, last2;

   reg_mem_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .WR_en(WR_en), .WR_addr(WR_addr), .WR_data(WR_data),
      .RD_en1(RD_en1), .RD_addr1(RD_addr1),
      .RD_en2(RD_en2), .RD_addr2(RD_addr2),
      .RD_out1(RD_out1), .RD_out2(RD_out2),
      .RD_valid1(RD_valid1), .RD_valid2(RD_valid2),
      .wr_success(wr_success), .ready(ready)
   );

   reg_mem_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dz (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .WR_en(WR_en), .WR_addr(WR_addr), .WR_data(WR_data),
      .RD_en1(RD_en1), .RD_addr1(RD_addr1),
      .RD_en2(RD_en2), .RD_addr2(RD_addr2),
      .RD_out1(rz1), .RD_out2(rz2),
      .RD_valid1(vz1), .RD_valid2(vz2),
      .wr_success(wsz), .ready(rdyz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr_req = 1'b0;
      WR_en   = 1'b0;
      RD_en1  = 1'b0;
      RD_en2  = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      idle();
      tick();
      tick();
      n_tests++;
      if (ready !== 1'b0 || wr_success !== 1'b0 || RD_valid1 !== 1'b0 || RD_valid2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready=%b wr_success=%b v1=%b v2=%b, required all 0",
                  ready, wr_success, RD_valid1, RD_valid2);
      end
      n_tests++;
      if (RD_out1 !== 8'h00 || RD_out2 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_out: out1=%h out2=%h, required 00 00", RD_out1, RD_out2);
      end
      rst = 1'b0;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (ready !== 1'b1 && cnt < 40);
      n_tests++;
      if (cnt != 8) begin
         n_fail++;
         $display("FAIL reset_sweep_len: ready after %0d cycles, required 8", cnt);
      end
      for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         RD_en1 = 1'b1; RD_addr1 = 3'(i);
         RD_en2 = 1'b1; RD_addr2 = 3'(7 - i);
         q1.push_back(exp_mem[i]);
         q2.push_back(exp_mem[7 - i]);
         tick();
         e1 = q1.pop_front();
         e2 = q2.pop_front();
         n_tests++;
         if (RD_valid1 !== 1'b1 || RD_out1 !== e1 || RD_valid2 !== 1'b1 || RD_out2 !== e2) begin
            n_fail++;
            $display("FAIL reset_readback[%0d]: v1=%b out1=%h v2=%b out2=%h, required 1 %h 1 %h",
                     i, RD_valid1, RD_out1, RD_valid2, RD_out2, e1, e2);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_write_read();
      WR_en = 1'b1; WR_addr = 3'd1; WR_data = 8'h03;
      tick();
      exp_mem[1] = 8'h03;
      WR_en = 1'b0;
      n_tests++;
      if (wr_success !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_pulse: wr_success=%b, required 1", wr_success);
      end
      RD_en1 = 1'b1; RD_addr1 = 3'd1;
      q1.push_back(exp_mem[1]);
      tick();
      RD_en1 = 1'b0;
      n_tests++;
      if (wr_success !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_pulse_end: wr_success=%b, required 0", wr_success);
      end
      e1 = q1.pop_front();
      n_tests++;
      if (RD_valid1 !== 1'b1 || RD_out1 !== e1) begin
         n_fail++;
         $display("FAIL read1: v1=%b out1=%h, required 1 %h", RD_valid1, RD_out1, e1);
      end
      tick();
      n_tests++;
      if (RD_valid1 !== 1'b0 || RD_out1 !== e1) begin
         n_fail++;
         $display("FAIL read1_hold: v1=%b out1=%h, required 0 %h", RD_valid1, RD_out1, e1);
      end
   endtask

   task automatic test_bypass_dual();
      WR_en = 1'b1; WR_addr = 3'd2; WR_data = 8'h05;
      RD_en1 = 1'b1; RD_addr1 = 3'd2;
      RD_en2 = 1'b1; RD_addr2 = 3'd2;
      exp_mem[2] = 8'h05;
      q1.push_back(8'h05);
      q2.push_back(8'h05);
      tick();
      idle();
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      n_tests++;
      if (RD_valid1 !== 1'b1 || RD_out1 !== e1 || RD_valid2 !== 1'b1 || RD_out2 !== e2 || wr_success !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_dual: v1=%b out1=%h v2=%b out2=%h ws=%b, required 1 %h 1 %h 1",
                  RD_valid1, RD_out1, RD_valid2, RD_out2, wr_success, e1, e2);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      for (int a = 3; a < 8; a++) begin
         d = 8'($urandom_range(1, 255));
         WR_en = 1'b1; WR_addr = 3'(a); WR_data = d;
         exp_mem[a] = d;
         tick();
         n_tests++;
         if (wr_success !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_wr[%0d]: wr_success=%b, required 1", a, wr_success);
         end
      end
      WR_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         RD_en1 = 1'b1; RD_addr1 = 3'(i);
         RD_en2 = 1'b1; RD_addr2 = 3'(7 - i);
         q1.push_back(exp_mem[i]);
         q2.push_back(exp_mem[7 - i]);
         tick();
         e1 = q1.pop_front();
         e2 = q2.pop_front();
         n_tests++;
         if (RD_valid1 !== 1'b1 || RD_out1 !== e1 || RD_valid2 !== 1'b1 || RD_out2 !== e2) begin
            n_fail++;
            $display("FAIL b2b_rd[%0d]: v1=%b out1=%h v2=%b out2=%h, required 1 %h 1 %h",
                     i, RD_valid1, RD_out1, RD_valid2, RD_out2, e1, e2);
         end
         last1 = e1;
         last2 = e2;
      end
      idle();
      tick();
      n_tests++;
      if (wr_success !== 1'b0 || RD_valid1 !== 1'b0 || RD_valid2 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: ws=%b v1=%b v2=%b, required 0 0 0", wr_success, RD_valid1, RD_valid2);
      end
   endtask

   task automatic test_clear_priority();
      int cnt;
      bit bad;
      clr_req = 1'b1;
      WR_en = 1'b1; WR_addr = 3'd4; WR_data = 8'hAA;
      tick();
      n_tests++;
      if (wr_success !== 1'b0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_priority: ws=%b ready=%b, required 0 0", wr_success, ready);
      end
      n_tests++;
      if (RD_out1 !== last1 || RD_out2 !== last2) begin
         n_fail++;
         $display("FAIL clr_hold_out: out1=%h out2=%h, required %h %h", RD_out1, RD_out2, last1, last2);
      end
      RD_en1 = 1'b1; RD_addr1 = 3'd3;
      cnt = 0;
      bad = 1'b0;
      do begin
         tick();
         cnt++;
         if (wr_success !== 1'b0 || RD_valid1 !== 1'b0) bad = 1'b1;
         if (cnt == 3) clr_req = 1'b0;
      end while (ready !== 1'b1 && cnt < 40);
      idle();
      n_tests++;
      if (cnt != 8 || bad) begin
         n_fail++;
         $display("FAIL clr_sweep: ready after %0d cycles (stray=%b), required 8 (stray=0)", cnt, bad);
      end
      n_tests++;
      if (RD_out1 !== last1) begin
         n_fail++;
         $display("FAIL clr_hold_out_end: out1=%h, required %h", RD_out1, last1);
      end
      for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
      RD_en1 = 1'b1; RD_addr1 = 3'd4;
      RD_en2 = 1'b1; RD_addr2 = 3'd1;
      q1.push_back(exp_mem[4]);
      q2.push_back(exp_mem[1]);
      tick();
      idle();
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      n_tests++;
      if (RD_valid1 !== 1'b1 || RD_out1 !== e1 || RD_valid2 !== 1'b1 || RD_out2 !== e2) begin
         n_fail++;
         $display("FAIL clr_readback: v1=%b out1=%h v2=%b out2=%h, required 1 %h 1 %h",
                  RD_valid1, RD_out1, RD_valid2, RD_out2, e1, e2);
      end
      tick();
   endtask

   task automatic test_zero_reg();
      WR_en = 1'b1; WR_addr = 3'd0; WR_data = 8'hFF;
      exp_mem[0] = 8'hFF;
      tick();
      WR_en = 1'b0;
      n_tests++;
      if (wsz !== 1'b0 || wr_success !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_wr: zero-reg ws=%b plain ws=%b, required 0 1", wsz, wr_success);
      end
      RD_en1 = 1'b1; RD_addr1 = 3'd0;
      q1.push_back(exp_mem[0]);
      qz.push_back(8'h00);
      tick();
      RD_en1 = 1'b0;
      e1 = q1.pop_front();
      ez = qz.pop_front();
      n_tests++;
      if (vz1 !== 1'b1 || rz1 !== ez || RD_out1 !== e1) begin
         n_fail++;
         $display("FAIL zero_rd: zero-reg v=%b out=%h plain out=%h, required 1 %h %h", vz1, rz1, RD_out1, ez, e1);
      end
      WR_en = 1'b1; WR_addr = 3'd0; WR_data = 8'h77;
      RD_en2 = 1'b1; RD_addr2 = 3'd0;
      exp_mem[0] = 8'h77;
      q2.push_back(8'h77);
      qz.push_back(8'h00);
      tick();
      idle();
      e2 = q2.pop_front();
      ez = qz.pop_front();
      n_tests++;
      if (vz2 !== 1'b1 || rz2 !== ez || RD_out2 !== e2 || wsz !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_bypass: zero-reg out2=%h ws=%b plain out2=%h, required %h 0 %h", rz2, wsz, RD_out2, ez, e2);
      end
      tick();
   endtask

   task automatic test_rst_mid_sweep();
      int cnt;
      bit bad;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      WR_en = 1'b1; WR_addr = 3'd5; WR_data = 8'h3C;
      tick();
      n_tests++;
      if (wr_success !== 1'b0 || ready !== 1'b0 || RD_out1 !== 8'h00 || RD_out2 !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid: ws=%b ready=%b out1=%h out2=%h, required 0 0 00 00",
                  wr_success, ready, RD_out1, RD_out2);
      end
      rst = 1'b0;
      cnt = 0;
      bad = 1'b0;
      do begin
         tick();
         cnt++;
         if (wr_success !== 1'b0) bad = 1'b1;
      end while (ready !== 1'b1 && cnt < 40);
      idle();
      n_tests++;
      if (cnt != 8 || bad) begin
         n_fail++;
         $display("FAIL rst_sweep: ready after %0d cycles (stray ws=%b), required 8 (0)", cnt, bad);
      end
      for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
      RD_en1 = 1'b1; RD_addr1 = 3'd5;
      q1.push_back(exp_mem[5]);
      tick();
      idle();
      e1 = q1.pop_front();
      n_tests++;
      if (RD_valid1 !== 1'b1 || RD_out1 !== e1 || wr_success !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_readback: v1=%b out1=%h ws=%b, required 1 %h 0", RD_valid1, RD_out1, wr_success, e1);
      end
   endtask

   initial begin
      rst = 1'b1;
      clr_req = 1'b0;
      WR_en = 1'b0; WR_addr = '0; WR_data = '0;
      RD_en1 = 1'b0; RD_addr1 = '0;
      RD_en2 = 1'b0; RD_addr2 = '0;
      last1 = '0; last2 = '0;
      test_reset();
      test_write_read();
      test_bypass_dual();
      test_back_to_back();
      test_clear_priority();
      test_zero_reg();
      test_rst_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
